// File: rtl/map_table.sv
// Register rename map: tracks, per architectural register, which in-flight ROB
// entry will produce it and whether that result has been broadcast yet.
module map_table #(
  parameter  int unsigned ROB_LEN   = 8,
  parameter  int unsigned NUM_AREGS = 32,
  localparam int unsigned TAG_W     = (ROB_LEN > 1) ? $clog2(ROB_LEN) : 1,
  localparam int unsigned IDX_W     = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             dp_valid,
  input  logic [IDX_W-1:0] dp_dest_idx,
  input  logic [TAG_W-1:0] dp_rob_tag,
  input  logic             dp_rob_full,
  input  logic [IDX_W-1:0] rs1_idx,
  input  logic [IDX_W-1:0] rs2_idx,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             rt_valid,
  input  logic [TAG_W-1:0] rt_head_idx,
  input  logic             squash,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  output logic             rs1_renamed,
  output logic             rs2_renamed,
  output logic             rs1_ready,
  output logic             rs2_ready
);

  logic [NUM_AREGS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [NUM_AREGS-1:0]            renamed_q, renamed_d;
  logic [NUM_AREGS-1:0]            ready_q, ready_d;
  logic                            dp_we;

  // Per-entry update; priority squash > dispatch > retire > CDB.
  always_comb begin
    tag_d     = tag_q;
    renamed_d = renamed_q;
    ready_d   = ready_q;
    dp_we     = dp_valid & ~stall & ~dp_rob_full & (dp_dest_idx != '0);
    for (int unsigned r = 0; r < NUM_AREGS; r++) begin
      if (squash) begin
        tag_d[r]     = '0;
        renamed_d[r] = 1'b0;
        ready_d[r]   = 1'b0;
      end else if (dp_we && (dp_dest_idx == IDX_W'(r))) begin
        tag_d[r]     = dp_rob_tag;
        renamed_d[r] = 1'b1;
        ready_d[r]   = 1'b0;
      end else if (rt_valid && renamed_q[r] && (tag_q[r] == rt_head_idx)) begin
        // A re-renamed entry holds a newer tag, so a stale retire misses here.
        tag_d[r]     = '0;
        renamed_d[r] = 1'b0;
        ready_d[r]   = 1'b0;
      end else if (cdb_valid && renamed_q[r] && (tag_q[r] == cdb_tag)) begin
        ready_d[r]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q     <= '0;
      renamed_q <= '0;
      ready_q   <= '0;
    end else begin
      tag_q     <= tag_d;
      renamed_q <= renamed_d;
      ready_q   <= ready_d;
    end
  end

  // Source lookups from registered state; x0 always reads zeros, CDB is bypassed.
  always_comb begin
    rs1_tag     = '0;
    rs1_renamed = 1'b0;
    rs1_ready   = 1'b0;
    rs2_tag     = '0;
    rs2_renamed = 1'b0;
    rs2_ready   = 1'b0;
    for (int unsigned r = 1; r < NUM_AREGS; r++) begin
      if (rs1_idx == IDX_W'(r)) begin
        rs1_tag     = tag_q[r];
        rs1_renamed = renamed_q[r];
        rs1_ready   = renamed_q[r] & (ready_q[r] | (cdb_valid & (tag_q[r] == cdb_tag)));
      end
      if (rs2_idx == IDX_W'(r)) begin
        rs2_tag     = tag_q[r];
        rs2_renamed = renamed_q[r];
        rs2_ready   = renamed_q[r] & (ready_q[r] | (cdb_valid & (tag_q[r] == cdb_tag)));
      end
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Bench for map_table: directed scenarios plus random traffic, all checked
// against a simple array model of the rename map.
module tb_map_table;

  logic       clock;
  logic       reset;
  logic       stall;
  logic       dp_valid;
  logic [4:0] dp_dest_idx;
  logic [2:0] dp_rob_tag;
  logic       dp_rob_full;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic       cdb_valid;
  logic [2:0] cdb_tag;
  logic       rt_valid;
  logic [2:0] rt_head_idx;
  logic       squash;
  logic [2:0] rs1_tag;
  logic [2:0] rs2_tag;
  logic       rs1_renamed;
  logic       rs2_renamed;
  logic       rs1_ready;
  logic       rs2_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what each architectural register maps to.
  int m_tag [32];
  bit m_ren [32];
  bit m_rdy [32];

  map_table dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .dp_valid    (dp_valid),
    .dp_dest_idx (dp_dest_idx),
    .dp_rob_tag  (dp_rob_tag),
    .dp_rob_full (dp_rob_full),
    .rs1_idx     (rs1_idx),
    .rs2_idx     (rs2_idx),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .rt_valid    (rt_valid),
    .rt_head_idx (rt_head_idx),
    .squash      (squash),
    .rs1_tag     (rs1_tag),
    .rs2_tag     (rs2_tag),
    .rs1_renamed (rs1_renamed),
    .rs2_renamed (rs2_renamed),
    .rs1_ready   (rs1_ready),
    .rs2_ready   (rs2_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic int exp_tag(input int i);
    return (i == 0) ? 0 : m_tag[i];
  endfunction

  function automatic int exp_ren(input int i);
    return (i == 0) ? 0 : int'(m_ren[i]);
  endfunction

  function automatic int exp_rdy(input int i);
    if (i == 0 || !m_ren[i]) return 0;
    if (m_rdy[i]) return 1;
    return (cdb_valid && (m_tag[i] == int'(cdb_tag))) ? 1 : 0;
  endfunction

  task automatic compare_model();
    check("rs1_tag",     int'(rs1_tag),     exp_tag(int'(rs1_idx)));
    check("rs1_renamed", int'(rs1_renamed), exp_ren(int'(rs1_idx)));
    check("rs1_ready",   int'(rs1_ready),   exp_rdy(int'(rs1_idx)));
    check("rs2_tag",     int'(rs2_tag),     exp_tag(int'(rs2_idx)));
    check("rs2_renamed", int'(rs2_renamed), exp_ren(int'(rs2_idx)));
    check("rs2_ready",   int'(rs2_ready),   exp_rdy(int'(rs2_idx)));
  endtask

  // Apply effects lowest priority first so later ones overwrite: CDB, retire, dispatch.
  task automatic model_update();
    int ot [32];
    bit orn [32];
    bit we;
    if (reset || squash) begin
      for (int r = 0; r < 32; r++) begin
        m_tag[r] = 0; m_ren[r] = 0; m_rdy[r] = 0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        ot[r] = m_tag[r]; orn[r] = m_ren[r];
      end
      for (int r = 0; r < 32; r++)
        if (cdb_valid && orn[r] && ot[r] == int'(cdb_tag)) m_rdy[r] = 1;
      for (int r = 0; r < 32; r++)
        if (rt_valid && orn[r] && ot[r] == int'(rt_head_idx)) begin
          m_tag[r] = 0; m_ren[r] = 0; m_rdy[r] = 0;
        end
      we = dp_valid && !stall && !dp_rob_full && (dp_dest_idx != 0);
      if (we) begin
        m_tag[dp_dest_idx] = int'(dp_rob_tag);
        m_ren[dp_dest_idx] = 1;
        m_rdy[dp_dest_idx] = 0;
      end
    end
  endtask

  // Inputs are driven just after a falling edge; check, advance model, step one clock.
  task automatic cycle();
    #1;
    compare_model();
    model_update();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    stall = 0; dp_valid = 0; dp_dest_idx = '0; dp_rob_tag = '0; dp_rob_full = 0;
    rs1_idx = '0; rs2_idx = '0; cdb_valid = 0; cdb_tag = '0;
    rt_valid = 0; rt_head_idx = '0; squash = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic dispatch(input int dest, input int tag);
    clear_inputs();
    dp_valid = 1; dp_dest_idx = 5'(dest); dp_rob_tag = 3'(tag);
    cycle();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    for (int r = 0; r < 32; r++) begin
      m_tag[r] = 0; m_ren[r] = 0; m_rdy[r] = 0;
    end
    @(negedge clock);
    do_reset();

    // Post-reset: every register reads zeros.
    clear_inputs(); rs1_idx = 5'd5; rs2_idx = 5'd31; #1;
    check("rst_rs1_ren", int'(rs1_renamed), 0);
    check("rst_rs2_tag", int'(rs2_tag), 0);
    cycle();

    // Dispatch, lookup, CDB bypass, ready held.
    dispatch(5, 3);
    clear_inputs(); rs1_idx = 5'd5; #1;
    check("d036_tag", int'(rs1_tag), 3);
    check("d036_ren", int'(rs1_renamed), 1);
    check("d036_rdy", int'(rs1_ready), 0);
    cycle();
    rs1_idx = 5'd5; cdb_valid = 1; cdb_tag = 3'd3; #1;
    check("d036_bypass", int'(rs1_ready), 1);
    cycle();
    clear_inputs(); rs1_idx = 5'd5; #1;
    check("d036_held", int'(rs1_ready), 1);
    cycle();

    // Stale retire leaves a re-renamed entry alone.
    do_reset();
    dispatch(5, 2);
    dispatch(5, 6);
    clear_inputs(); rt_valid = 1; rt_head_idx = 3'd2; rs1_idx = 5'd5;
    cycle();
    clear_inputs(); rs1_idx = 5'd5; #1;
    check("d037_tag", int'(rs1_tag), 6);
    check("d037_ren", int'(rs1_renamed), 1);
    rt_valid = 1; rt_head_idx = 3'd6; #1;
    check("d037_noretbyp", int'(rs1_renamed), 1);
    cycle();
    clear_inputs(); rs1_idx = 5'd5; #1;
    check("d037_retired", int'(rs1_renamed), 0);
    cycle();

    // Lookup sees the mapping from before the same-cycle dispatch.
    dispatch(7, 1);
    clear_inputs(); dp_valid = 1; dp_dest_idx = 5'd7; dp_rob_tag = 3'd4; rs1_idx = 5'd7; #1;
    check("d038_old", int'(rs1_tag), 1);
    cycle();
    clear_inputs(); rs1_idx = 5'd7; #1;
    check("d038_new", int'(rs1_tag), 4);
    cycle();

    // Blocked dispatches and x0.
    do_reset();
    clear_inputs(); dp_valid = 1; dp_dest_idx = 5'd0; dp_rob_tag = 3'd3; cycle();
    clear_inputs(); dp_valid = 1; dp_dest_idx = 5'd8; dp_rob_tag = 3'd2; stall = 1; cycle();
    clear_inputs(); dp_valid = 1; dp_dest_idx = 5'd8; dp_rob_tag = 3'd2; dp_rob_full = 1; cycle();
    clear_inputs(); rs1_idx = 5'd8; rs2_idx = 5'd0; #1;
    check("d039_x8_ren", int'(rs1_renamed), 0);
    check("d039_x0_tag", int'(rs2_tag), 0);
    check("d039_x0_ren", int'(rs2_renamed), 0);
    check("d039_x0_rdy", int'(rs2_ready), 0);
    cycle();

    // Squash beats a same-cycle dispatch.
    dispatch(1, 0);
    dispatch(2, 1);
    dispatch(3, 7);
    clear_inputs(); squash = 1; dp_valid = 1; dp_dest_idx = 5'd4; dp_rob_tag = 3'd5; cycle();
    for (int i = 1; i <= 4; i++) begin
      clear_inputs(); rs1_idx = 5'(i); #1;
      check("d040_squashed", int'(rs1_renamed), 0);
      cycle();
    end

    // Dispatch wins over retire of the same wrapped tag.
    dispatch(9, 5);
    clear_inputs(); dp_valid = 1; dp_dest_idx = 5'd9; dp_rob_tag = 3'd5;
    rt_valid = 1; rt_head_idx = 3'd5; cycle();
    clear_inputs(); rs1_idx = 5'd9; #1;
    check("d041_tag", int'(rs1_tag), 5);
    check("d041_ren", int'(rs1_renamed), 1);
    check("d041_rdy", int'(rs1_ready), 0);
    cycle();

    // Mid-operation reset drops all mappings.
    dispatch(3, 4);
    clear_inputs(); reset = 1; squash = 0; cycle();
    reset = 0; clear_inputs(); rs1_idx = 5'd3; rs2_idx = 5'd9; #1;
    check("midrst_ren1", int'(rs1_renamed), 0);
    check("midrst_ren2", int'(rs2_renamed), 0);
    cycle();

    // Random traffic over a small register window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      squash      = ($urandom_range(0, 59) == 0);
      stall       = ($urandom_range(0, 7) == 0);
      dp_rob_full = ($urandom_range(0, 9) == 0);
      dp_valid    = ($urandom_range(0, 3) != 0);
      dp_dest_idx = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      dp_rob_tag  = 3'($urandom);
      cdb_valid   = ($urandom_range(0, 1) == 0);
      cdb_tag     = 3'($urandom);
      rt_valid    = ($urandom_range(0, 2) == 0);
      rt_head_idx = 3'($urandom);
      rs1_idx     = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs2_idx     = 5'($urandom_range(0, 8));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/map_table.md
MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 Parameter ROB_LEN, default 8, number of reorder-buffer entries; TAG_W = clog2(ROB_LEN).
REQ-002 Parameter NUM_AREGS, default 32, number of architectural registers; IDX_W = 5.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  pipeline stall; when high, blocks dispatch rename writes.
REQ-006 dp_valid  input  1  a dispatching instruction is present this cycle.
REQ-007 dp_dest_idx  input  IDX_W  architectural destination of the dispatching instruction.
REQ-008 dp_rob_tag  input  TAG_W  ROB tail index allocated to the dispatching instruction.
REQ-009 dp_rob_full  input  1  ROB structural hazard; when high, blocks dispatch rename writes.
REQ-010 rs1_idx, rs2_idx  input  IDX_W each  source register indices to look up.
REQ-011 cdb_valid  input  1  a result is broadcast on the CDB this cycle.
REQ-012 cdb_tag  input  TAG_W  ROB tag of the broadcast result.
REQ-013 rt_valid  input  1  the ROB head retires this cycle.
REQ-014 rt_head_idx  input  TAG_W  ROB head index being retired.
REQ-015 squash  input  1  mispredict flush from the ROB.
REQ-016 rs1_tag, rs2_tag  output  TAG_W each  ROB tag currently mapped to the source.
REQ-017 rs1_renamed, rs2_renamed  output  1 each  source is produced by an in-flight ROB entry.
REQ-018 rs1_ready, rs2_ready  output  1 each  mapped ROB entry has completed; value obtainable from the ROB.

Function
REQ-019 State per architectural register r: tag[r] (TAG_W), renamed[r] (1), ready[r] (1); NUM_AREGS entries total.
REQ-020 Dispatch write enable dp_we = dp_valid & ~stall & ~dp_rob_full & (dp_dest_idx != 0).
REQ-021 On dp_we: tag[dp_dest_idx] <= dp_rob_tag, renamed <= 1, ready <= 0 at the next edge.
REQ-022 Register 0 is never renamed; rs*_renamed = 0, rs*_ready = 0, rs*_tag = 0 whenever rs*_idx == 0.
REQ-023 CDB: every entry with renamed[r]=1 and tag[r]==cdb_tag gets ready[r] <= 1 while cdb_valid=1.
REQ-024 Retire: every entry with renamed[r]=1 and tag[r]==rt_head_idx gets renamed <= 0, ready <= 0, tag <= 0 while rt_valid=1.
REQ-025 Priority per entry, highest first: squash, dispatch write, retire clear, CDB ready set.
REQ-026 Squash: next edge clears renamed, ready, and tag for all entries; dispatch, CDB, and retire inputs are ignored that cycle.
REQ-027 Lookup is combinational: 0-cycle latency from registered state.
REQ-028 Lookups see state before the same-cycle dispatch write; an instruction whose source equals its own destination reads the prior mapping.
REQ-029 CDB bypass: if the looked-up entry is renamed and its tag equals cdb_tag with cdb_valid=1, rs*_ready = 1 in that same cycle.
REQ-030 Retire is not bypassed; a retiring mapping still reads renamed=1 during its retire cycle.
REQ-031 Tag comparisons are exact TAG_W-bit equality; tags wrap modulo ROB_LEN with no special handling.
REQ-032 Stale-retire guard: if an entry was re-renamed to a newer tag, retirement of the older tag leaves it unchanged.

Reset
REQ-033 While reset=1 at a clock edge, all tag, renamed, and ready state clears to 0; reset overrides squash and all other inputs.
REQ-034 After reset, all outputs are 0 for any rs*_idx until a dispatch write occurs.
REQ-035 Reset asserted mid-operation discards all mappings within one edge; no partial state survives.

Verification
REQ-036 Dispatch x5 -> tag 3, then look up rs1=5 -> rs1_tag=3, renamed=1, ready=0; cdb_valid, cdb_tag=3 the next cycle -> rs1_ready=1 in the same cycle (bypass) and held afterwards.
REQ-037 Dispatch x5 -> tag 2, then x5 -> tag 6; retire head 2 -> x5 stays tag 6, renamed=1; retire head 6 -> renamed=0.
REQ-038 Single-cycle dispatch of dest x7, tag 4, with rs1=7 while x7 is mapped to tag 1 -> rs1_tag=1; the following cycle rs1_tag=4.
REQ-039 Dispatch to x0, or dispatch with stall=1 or dp_rob_full=1 -> no state change; rs1=0 reads all zeros.
REQ-040 Map x1/x2/x3 to tags 0/1/7, assert squash together with dp_valid (x4, tag 5) -> every entry, including x4, reads renamed=0 next cycle.
REQ-041 Same-cycle dispatch x9 -> tag 5 and retire of x9's old tag 5 (wrapped reuse) -> dispatch wins; x9 reads tag 5, renamed=1, ready=0.
